inv_key_expansion: RTL

- Sequential AES-128 reverse key scheduler for the decryption datapath; the inverse direction of the forward one-round key expansion.
- Takes the round-10 key and emits round keys 10, 9, ..., 0, one per valid/ready transfer, in the order the inverse cipher consumes them.
- Each step registers the previous round key; the backward recurrence is computed combinationally from the current register.

---
 rtl/aes_pkg.sv | 64 ++++++
 rtl/inv_key_step.sv | 27 ++
 rtl/inv_key_expansion.sv | 126 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule helpers: S-box, round constants, word
// rotation/substitution and the scheduler state encoding. Used by both the
// forward and the reverse key expansion blocks.
package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        EMIT
    } aesStateT;

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sBox(input logic [7:0] b);
        return SBOX_TABLE[b];
    endfunction

    // Round constant for rounds 1..10; any other index yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] rotWord(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sBox(w[31:24]), sBox(w[23:16]), sBox(w[15:8]), sBox(w[7:0])};
    endfunction

endpackage

// File: rtl/inv_key_step.sv
// One backward AES-128 key-schedule step: from round key r and its index,
// reconstruct round key r-1. Purely combinational.
module inv_key_step
    import aes_pkg::*;
(
    input  logic [0:127] roundKey,
    input  logic [0:3]   roundIdx,
    output logic [0:127] prevKey
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;

    // Undo the forward XOR chain word by word, then rebuild word 0 from the recovered word 3
    always_comb begin
        w0 = roundKey[0:31];
        w1 = roundKey[32:63];
        w2 = roundKey[64:95];
        w3 = roundKey[96:127];
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        p0 = w0 ^ subWord(rotWord(p3)) ^ {rcon(roundIdx), 24'h000000};
        prevKey = {p0, p1, p2, p3};
    end

endmodule

// File: rtl/inv_key_expansion.sv
// Sequential AES-128 reverse key scheduler. Loads the round-10 key and hands
// out round keys 10 down to 0 over a valid/ready interface.
// Optional macro FWD_PRECOMPUTE_EN: key_in is the cipher key instead, and the
// block first runs the forward schedule for NR cycles (PRE state) to reach
// the round-10 key before emitting.
module inv_key_expansion
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk_out,
    output logic [0:3]   rk_round,
    output logic         done
);

    if (NR != NR_AES128) begin : gNrCheck
        $error("inv_key_expansion supports only AES-128 with NR = 10");
    end

    aesStateT     state;
    logic [0:127] keyReg;
    logic [3:0]   roundCnt;
    logic [0:127] prevKey;
    logic         rkValidReg;
    logic         busyReg;
    logic         doneReg;
    logic         transfer;

    inv_key_step uStep (
        .roundKey (keyReg),
        .roundIdx (roundCnt),
        .prevKey  (prevKey)
    );

`ifdef FWD_PRECOMPUTE_EN
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  n0, n1, n2, n3;
    logic [0:127] nextFwdKey;

    // Forward expansion step from the key register, using the PRE counter as round index
    always_comb begin
        f0 = keyReg[0:31];
        f1 = keyReg[32:63];
        f2 = keyReg[64:95];
        f3 = keyReg[96:127];
        n0 = f0 ^ subWord(rotWord(f3)) ^ {rcon(roundCnt), 24'h000000};
        n1 = n0 ^ f1;
        n2 = n1 ^ f2;
        n3 = n2 ^ f3;
        nextFwdKey = {n0, n1, n2, n3};
    end
`endif

    assign transfer = rkValidReg & rk_ready;

    // Scheduler FSM: load, optional forward precompute, then step backwards one key per accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            keyReg     <= '0;
            roundCnt   <= 4'd0;
            rkValidReg <= 1'b0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        keyReg  <= key_in;
                        busyReg <= 1'b1;
`ifdef FWD_PRECOMPUTE_EN
                        roundCnt <= 4'd1;
                        state    <= PRE;
`else
                        roundCnt   <= 4'(NR);
                        rkValidReg <= 1'b1;
                        state      <= EMIT;
`endif
                    end
                end
`ifdef FWD_PRECOMPUTE_EN
                PRE: begin
                    keyReg <= nextFwdKey;
                    if (roundCnt == 4'(NR)) begin
                        rkValidReg <= 1'b1;
                        state      <= EMIT;
                    end else begin
                        roundCnt <= roundCnt + 4'd1;
                    end
                end
`endif
                EMIT: begin
                    if (transfer) begin
                        if (roundCnt == 4'd0) begin
                            rkValidReg <= 1'b0;
                            busyReg    <= 1'b0;
                            doneReg    <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            keyReg   <= prevKey;
                            roundCnt <= roundCnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busyReg;
    assign rk_valid = rkValidReg;
    assign rk_out   = keyReg;
    assign rk_round = roundCnt;
    assign done     = doneReg;

endmodule
